// File: rtl/rpn_stack_engine.sv
// RPN calculator core: decodes PS/2 make codes into a DEPTH-entry unsigned stack
// and echoes key entry and results to the VGA text writer.
module rpn_stack_engine #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int DIGITS = 10,
  parameter int COLS   = 64,
  parameter int LINES  = 30
) (
  input  logic                       CLK_25M,
  input  logic                       Reset,
  input  logic                       Key_Valid,
  input  logic [7:0]                 Key_Code,
  input  logic                       Key_Ext,
  input  logic                       Write_Ready,
  output logic [4:0]                 Line,
  output logic [6:0]                 Character,
  output logic [7:0]                 Glyph,
  output logic                       Glyph_Write,
  output logic [WIDTH-1:0]           Top_Value,
  output logic [$clog2(DEPTH):0]     Depth,
  output logic                       Carry,
  output logic [1:0]                 Err_Code,
  output logic                       Busy
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DIGITS * 4;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, B2B, PUSH, OP, CONV, EMIT, NL} state_t;

  state_t            state_q, state_d, nl_ret_q, nl_ret_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic [NW-1:0]     n_q, n_d, bidx_q, bidx_d, idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_pend_q, op_pend_d, op_sub_q, op_sub_d;
  logic              carry_q, carry_d;
  logic [1:0]        err_q, err_d;
  logic [4:0]        cur_line_q, cur_line_d, line_q, line_d;
  logic [6:0]        cur_col_q, cur_col_d, char_q, char_d;
  logic [7:0]        glyph_q, glyph_d, echo_glyph_q, echo_glyph_d;
  logic              gw_q, gw_d, echo_q, echo_d, echo_adv_q, echo_adv_d;
  logic [WIDTH-1:0]  acc_q, acc_d, bin_q, bin_d;
  logic [EW-1:0]     bcd_q, bcd_d;

  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic              st_we;
  logic [AW-1:0]     st_waddr;
  logic [WIDTH-1:0]  st_wdata;

  logic [AW-1:0]     top_idx, sec_idx;
  logic [WIDTH-1:0]  top_val, sec_val;
  logic [WIDTH:0]    sum;
  logic [4:0]        dig;
  logic              is_op;

  // {valid, digit} for the PS/2 number-row make codes
  function automatic logic [4:0] digit_decode(input logic [7:0] code);
    case (code)
      8'h16: return 5'h11;
      8'h1E: return 5'h12;
      8'h26: return 5'h13;
      8'h25: return 5'h14;
      8'h2E: return 5'h15;
      8'h36: return 5'h16;
      8'h3D: return 5'h17;
      8'h3E: return 5'h18;
      8'h46: return 5'h19;
      8'h45: return 5'h10;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [EW+WIDTH-1:0] dabble_step(input logic [EW-1:0] bcd,
                                                      input logic [WIDTH-1:0] bin);
    logic [EW-1:0] t;
    t = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    return {t, bin} << 1;
  endfunction

  // Index of the most significant non-zero digit (0 when the value is 0)
  function automatic logic [NW-1:0] lead_idx(input logic [EW-1:0] bcd);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[i*4 +: 4] != 4'd0) r = NW'(i);
    return r;
  endfunction

  function automatic logic [4:0] next_line(input logic [4:0] l);
    return (l == 5'(LINES - 1)) ? 5'd0 : l + 5'd1;
  endfunction

  assign top_idx = AW'(depth_q - DW'(1));
  assign sec_idx = AW'(depth_q - DW'(2));
  assign top_val = stack_q[top_idx];
  assign sec_val = stack_q[sec_idx];

  always_comb begin
    state_d      = state_q;
    nl_ret_d     = nl_ret_q;
    depth_d      = depth_q;
    entry_d      = entry_q;
    n_d          = n_q;
    bidx_d       = bidx_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    op_pend_d    = op_pend_q;
    op_sub_d     = op_sub_q;
    carry_d      = carry_q;
    err_d        = err_q;
    cur_line_d   = cur_line_q;
    cur_col_d    = cur_col_q;
    line_d       = line_q;
    char_d       = char_q;
    glyph_d      = glyph_q;
    gw_d         = gw_q;
    echo_d       = echo_q;
    echo_adv_d   = echo_adv_q;
    echo_glyph_d = echo_glyph_q;
    acc_d        = acc_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    st_we        = 1'b0;
    st_waddr     = '0;
    st_wdata     = '0;
    sum          = '0;
    dig          = digit_decode(Key_Code);
    is_op        = (Key_Code == 8'h55) || (Key_Code == 8'h79) ||
                   (Key_Code == 8'h4E) || (Key_Code == 8'h7B);

    unique case (state_q)
      IDLE: begin
        if (Key_Valid) begin
          if (dig[4]) begin
            if (n_q < NW'(DIGITS)) begin
              entry_d      = (entry_q << 4) | EW'(dig[3:0]);
              n_d          = n_q + 1'b1;
              echo_glyph_d = 8'h30 + {4'h0, dig[3:0]};
              echo_adv_d   = 1'b1;
              echo_d       = 1'b1;
              state_d      = EMIT;
            end else begin
              err_d = 2'd3;
            end
          end else if (Key_Code == 8'h66 && !Key_Ext) begin
            if (n_q != '0) begin
              entry_d      = entry_q >> 4;
              n_d          = n_q - 1'b1;
              cur_col_d    = (cur_col_q == 7'd0) ? 7'd0 : cur_col_q - 7'd1;
              echo_glyph_d = 8'h20;
              echo_adv_d   = 1'b0;
              echo_d       = 1'b1;
              state_d      = EMIT;
            end
          end else if (Key_Code == 8'h5A || is_op) begin
            op_pend_d = is_op;
            op_sub_d  = (Key_Code == 8'h4E) || (Key_Code == 8'h7B);
            if (n_q != '0) begin
              acc_d   = '0;
              bidx_d  = n_q - 1'b1;
              state_d = B2B;
            end else if (is_op) begin
              state_d = OP;
            end else if (depth_q != '0) begin
              acc_d   = top_val;
              state_d = PUSH;
            end else begin
              nl_ret_d = IDLE;
              state_d  = NL;
            end
          end else if (Key_Code == 8'h76) begin
            depth_d  = '0;
            entry_d  = '0;
            n_d      = '0;
            carry_d  = 1'b0;
            err_d    = 2'd0;
            nl_ret_d = IDLE;
            state_d  = NL;
          end
        end
      end

      B2B: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(entry_q[{bidx_q, 2'b00} +: 4]);
        if (bidx_q == '0) state_d = PUSH;
        else              bidx_d  = bidx_q - 1'b1;
      end

      PUSH: begin
        if (depth_q == DW'(DEPTH)) begin
          err_d = 2'd1;
        end else begin
          st_we    = 1'b1;
          st_waddr = AW'(depth_q);
          st_wdata = acc_q;
          depth_d  = depth_q + 1'b1;
          err_d    = 2'd0;
        end
        entry_d  = '0;
        n_d      = '0;
        nl_ret_d = op_pend_q ? OP : IDLE;
        state_d  = NL;
      end

      NL: begin
        cur_col_d  = 7'd0;
        cur_line_d = next_line(cur_line_q);
        state_d    = nl_ret_q;
      end

      OP: begin
        op_pend_d = 1'b0;
        if (depth_q < DW'(2)) begin
          err_d   = 2'd2;
          state_d = IDLE;
        end else begin
          // Top bit of the widened difference is the borrow
          sum      = op_sub_q ? ({1'b0, sec_val} - {1'b0, top_val})
                              : ({1'b0, sec_val} + {1'b0, top_val});
          carry_d  = sum[WIDTH];
          st_we    = 1'b1;
          st_waddr = sec_idx;
          st_wdata = sum[WIDTH-1:0];
          depth_d  = depth_q - 1'b1;
          err_d    = 2'd0;
          bin_d    = sum[WIDTH-1:0];
          bcd_d    = '0;
          cnt_d    = '0;
          echo_d   = 1'b0;
          // The pushing Enter already left the cursor at column 0
          if (cur_col_q != 7'd0) begin
            nl_ret_d = CONV;
            state_d  = NL;
          end else begin
            state_d = CONV;
          end
        end
      end

      CONV: begin
        {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          idx_d   = lead_idx(bcd_d);
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (!gw_q) begin
          if (Write_Ready) begin
            gw_d    = 1'b1;
            line_d  = cur_line_q;
            char_d  = cur_col_q;
            glyph_d = echo_q ? echo_glyph_q
                             : 8'h30 + {4'h0, bcd_q[{idx_q, 2'b00} +: 4]};
          end
        end else begin
          gw_d = 1'b0;
          if (!echo_q || echo_adv_q) begin
            if (cur_col_q == 7'(COLS - 1)) begin
              cur_col_d  = 7'd0;
              cur_line_d = next_line(cur_line_q);
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end
          if (echo_q) begin
            state_d = IDLE;
          end else if (idx_q == '0) begin
            nl_ret_d = IDLE;
            state_d  = NL;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_25M) begin
    if (Reset) begin
      state_q    <= IDLE;
      nl_ret_q   <= IDLE;
      depth_q    <= '0;
      entry_q    <= '0;
      n_q        <= '0;
      bidx_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      op_pend_q  <= 1'b0;
      op_sub_q   <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 2'd0;
      cur_line_q <= '0;
      cur_col_q  <= '0;
      line_q     <= '0;
      char_q     <= '0;
      glyph_q    <= '0;
      gw_q       <= 1'b0;
      echo_q     <= 1'b0;
      echo_adv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nl_ret_q   <= nl_ret_d;
      depth_q    <= depth_d;
      entry_q    <= entry_d;
      n_q        <= n_d;
      bidx_q     <= bidx_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      op_pend_q  <= op_pend_d;
      op_sub_q   <= op_sub_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      cur_line_q <= cur_line_d;
      cur_col_q  <= cur_col_d;
      line_q     <= line_d;
      char_q     <= char_d;
      glyph_q    <= glyph_d;
      gw_q       <= gw_d;
      echo_q     <= echo_d;
      echo_adv_q <= echo_adv_d;
    end
  end

  // Datapath state needs no reset: it is always loaded before it is read
  always_ff @(posedge CLK_25M) begin
    acc_q        <= acc_d;
    bin_q        <= bin_d;
    bcd_q        <= bcd_d;
    echo_glyph_q <= echo_glyph_d;
    if (st_we) stack_q[st_waddr] <= st_wdata;
  end

  assign Line        = line_q;
  assign Character   = char_q;
  assign Glyph       = glyph_q;
  assign Glyph_Write = gw_q;
  assign Top_Value   = (depth_q == '0) ? '0 : top_val;
  assign Depth       = depth_q;
  assign Carry       = carry_q;
  assign Err_Code    = err_q;
  assign Busy        = (state_q != IDLE);

endmodule
